// File: rtl/pattern_pkg.sv
// pattern_pkg: symbol encoding, serializer state encoding and length clamp
// shared by the pattern serializer and the BBCBC detector.
package pattern_pkg;

   localparam logic SYM_B = 1'b0;
   localparam logic SYM_C = 1'b1;

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] SHIFT      = 2'd1;
   localparam logic [1:0] SHIFT_FULL = 2'd2;

   // A length of zero or beyond the word size means a full word.
   function automatic int clamp_len(input int len, input int width);
      return (len == 0 || len > width) ? width : len;
   endfunction

endpackage

// File: rtl/pattern_ser_shreg.sv
// pattern_ser_shreg: loadable symbol shift register with remaining-symbol counter.
// PATTERN_SER_LSB_FIRST_EN selects data[0]-first emission; default is data[len-1]-first.
module pattern_ser_shreg
   import pattern_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   input  logic [CNT_W-1:0] len,
   output logic             head,
   output logic [CNT_W-1:0] cnt
);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] aligned;
   logic [WIDTH-1:0] shifted;

`ifdef PATTERN_SER_LSB_FIRST_EN
   always_comb begin
      aligned = din;
      shifted = {SYM_B, sr[WIDTH-1:1]};
      head    = sr[0];
   end
`else
   // Left-justify so data[len-1] sits at the head and bits above len fall off.
   always_comb begin
      aligned = din << (WIDTH - int'(len));
      shifted = {sr[WIDTH-2:0], SYM_B};
      head    = sr[WIDTH-1];
   end
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= aligned;
         cnt <= len;
      end else if (shift) begin
         sr  <= shifted;
         cnt <= cnt - CNT_W'(1);
      end

endmodule

// File: rtl/pattern_ser.sv
// pattern_ser: parallel-to-serial symbol feeder with a one-word holding buffer.
// Symbol order is set by PATTERN_SER_LSB_FIRST_EN (see pattern_ser_shreg).
module pattern_ser
   import pattern_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             wvalid_i,
   output logic             wready_o,
   input  logic             hold_i,
   output logic             d_o,
   output logic             valid_o,
   output logic             last_o,
   output logic             busy_o
);

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic             active_v;
   logic             pend_v;
   logic [WIDTH-1:0] pend;
   logic [CNT_W-1:0] pend_len;
   logic [CNT_W-1:0] len_c;
   logic [CNT_W-1:0] cnt;
   logic             head;
   logic             emit;
   logic             last_emit;
   logic             accept;
   logic             take_new;
   logic             load;
   logic             pend_we;
   logic [WIDTH-1:0] ld_data;
   logic [CNT_W-1:0] ld_len;

   assign len_c    = CNT_W'(clamp_len(int'(len_i), WIDTH));
   assign active_v = state != IDLE;
   assign pend_v   = state == SHIFT_FULL;
   assign wready_o = ~pend_v;
   assign busy_o   = active_v;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_comb
      state_nx = state == IDLE  ? (accept ? SHIFT : IDLE) :
                 state == SHIFT ? (last_emit ? (accept ? SHIFT : IDLE)
                                             : (accept ? SHIFT_FULL : SHIFT)) :
                 (last_emit ? SHIFT : SHIFT_FULL);

   // A new word bypasses the buffer when the active slot is free this edge.
   always_comb begin
      emit      = active_v & ~hold_i;
      last_emit = emit & (cnt == CNT_W'(1));
      accept    = wvalid_i & wready_o;
      take_new  = accept & (~active_v | last_emit);
      load      = take_new | (last_emit & pend_v);
      pend_we   = accept & ~take_new;
      ld_data   = take_new ? data_i : pend;
      ld_len    = take_new ? len_c : pend_len;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pend     <= '0;
         pend_len <= '0;
      end else if (pend_we) begin
         pend     <= data_i;
         pend_len <= len_c;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         d_o     <= SYM_B;
         valid_o <= 1'b0;
         last_o  <= 1'b0;
      end else begin
         valid_o <= emit;
         last_o  <= last_emit;
         if (emit) d_o <= head;
      end

   pattern_ser_shreg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_act (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (emit),
      .din   (ld_data),
      .len   (ld_len),
      .head  (head),
      .cnt   (cnt)
   );

endmodule

// File: doc/pattern_ser.md
# pattern_ser

Parallel-to-serial symbol feeder placed directly upstream of the Moore BBCBC pattern detector. It accepts words of up to WIDTH symbols over a valid/ready handshake and emits them one symbol per cycle on a registered serial output. Its serial outputs `d_o` and `valid_o` drive the detector's `d_i` and `valid_i`. A one-word holding buffer lets back-to-back words stream with no idle cycle between them.

## Interface
- WIDTH, 8: maximum symbols per word; legal range 2..32.
- CNT_W, $clog2(WIDTH+1): width of the length field; derived, never overridden.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  symbol word; bit value 0 = B, 1 = C.
- len_i  input  CNT_W  number of symbols to emit, taken from the low bits; 0 or >WIDTH means WIDTH.
- wvalid_i  input  1  word offered.
- wready_o  output  1  buffer can accept; equals !pend_v, derived from registers only.
- hold_i  input  1  stall; no symbol is emitted on an edge where it is sampled high.
- d_o  output  1  serial symbol (registered).
- valid_o  output  1  d_o carries a symbol this cycle (registered).
- last_o  output  1  d_o is the final symbol of its word (registered).
- busy_o  output  1  active_v | pend_v.

## Operation
- Storage:
  - Active shift register `act`, with remaining count `act_cnt` and flag `active_v`.
  - Pending word `pend` with `pend_len` and flag `pend_v`.
- A word is accepted on an edge where wvalid_i & wready_o.
- The accepted word goes into `act` if, on that same edge, either:
  - active_v=0, or
  - `act` emits its last symbol (act_cnt==1 & !hold_i).

  Otherwise it goes into `pend`.
- When `act` empties and pend_v=1, `pend` moves into `act` on the same edge and pend_v clears.
- Emit edge, defined as active_v & !hold_i:
  - d_o <= head symbol; valid_o <= 1; last_o <= (act_cnt==1).
  - `act` shifts one position; act_cnt decrements; active_v clears when the count reaches 0, unless reloaded.
- Non-emit edge: valid_o <= 0, last_o <= 0, d_o holds its previous value.
- Symbol order (default MSB-first): data_i[len-1] first, down to data_i[0]. Bits at or above len are ignored.
- States:
  - IDLE (!active_v & !pend_v) -> SHIFT on accept.
  - SHIFT (active_v & !pend_v):
    - -> SHIFT_FULL on accept while not finishing.
    - -> IDLE on last emit with no accept.
    - stays in SHIFT on last emit with a simultaneous accept.
  - SHIFT_FULL (active_v & pend_v): wready_o=0; -> SHIFT on last emit, as `pend` moves into `act`.
- Reset asserted mid-word:
  - All words are discarded immediately.
  - Outputs go to reset values asynchronously.
  - No partial word is resumed.

## Timing
- Reset values: d_o=0, valid_o=0, last_o=0, wready_o=1, busy_o=0.
- Latency: word accepted at edge k -> first symbol is valid on d_o after edge k+1.
- Throughput: one symbol per cycle while hold_i=0.
  - Consecutive words are seamless when the next word is offered no later than the edge that emits the previous word's last symbol.
- hold_i only stalls emission; acceptance into a free slot continues while held.
- wready_o depends on registered state only, with no combinational path from wvalid_i.

## Configuration
- PATTERN_SER_LSB_FIRST_EN:
  - Defined: symbols are emitted data_i[0] first, up to data_i[len-1].
  - Undefined: MSB-first as above.
  - Handshake and timing are identical in both builds.

## Structure
- Shared package pattern_pkg holds:
  - SYM_B=1'b0 and SYM_C=1'b1 (shared with the detector).
  - The state encoding localparams IDLE/SHIFT/SHIFT_FULL.
  - A len-clamp function.
- One sub-module, pattern_ser_shreg: loadable shift register with down-counter. It is instantiated once for `act`; the control FSM stays in pattern_ser.

## Test plan
- WIDTH=8, data_i=8'h05, len_i=5, hold_i=0 -> d_o sequence 0,0,1,0,1 on five consecutive cycles starting one cycle after accept; last_o high on the fifth only.
- Two words 8'h05/len 5 offered back-to-back -> ten consecutive valid_o cycles, no gap; wready_o low in SHIFT_FULL until the first word's last emit.
- hold_i high for 3 cycles mid-word -> valid_o low for exactly those 3 cycles, d_o held, sequence resumes intact.
- len_i=0 with data_i=8'hA5 -> 8 symbols 1,0,1,0,0,1,0,1; len_i=9 produces the same.
- rst asserted asynchronously during symbol 3 -> valid_o=0, wready_o=1, busy_o=0 immediately; the next word starts clean with its first symbol.
- Build with PATTERN_SER_LSB_FIRST_EN, data_i=8'h14, len_i=5 -> 0,0,1,0,1.
